// File: rtl/mcpu_mem_arbiter_if.sv
// Client and RAM-side signal bundle for the MCPU memory arbiter.
// The slave modport is the arbiter's view; master is the clients plus RAM.
interface mcpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic                  cpu_stall;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_lock;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;

    logic [DATA_WIDTH-1:0] rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_stall,
        output dbg_gnt, dbg_rvalid, rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_stall,
        input  dbg_gnt, dbg_rvalid, rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mcpu_mem_arbiter.sv
// Round-robin arbiter for the single-port MCPU RAM shared by the core and the debug port.
// Bounded hold per owner, debug lock on the CPU, registered read return tagged by owner.
//
// owner    | meaning
// OWN_NONE | RAM idle, no grant outstanding
// OWN_CPU  | core holds the RAM
// OWN_DBG  | debug/loader port holds the RAM
module mcpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_HOLD   = 4
) (
    input logic               clk,
    input logic               reset,
    mcpu_mem_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [1:0]            owner;
    logic [1:0]            owner_nxt;
    logic                  last_cpu;
    logic [HW-1:0]         hold_cnt;
    logic [HW-1:0]         hold_nxt;
    logic                  cpu_ok;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    logic                  cpu_rvalid;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    // The lock keeps the CPU out of arbitration entirely, both for new grants and handovers.
    assign cpu_ok = bus.cpu_req & ~bus.dbg_lock;

    always_comb begin
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        case (owner)
            OWN_NONE: begin
                hold_nxt = '0;
                if (cpu_ok && bus.dbg_req)
                    owner_nxt = last_cpu ? OWN_DBG : OWN_CPU;
                else if (cpu_ok)
                    owner_nxt = OWN_CPU;
                else if (bus.dbg_req)
                    owner_nxt = OWN_DBG;
            end
            OWN_CPU: begin
                if (bus.dbg_lock || !bus.cpu_req) begin
                    owner_nxt = bus.dbg_req ? OWN_DBG : OWN_NONE;
                    hold_nxt  = '0;
                end else if (bus.dbg_req && hold_cnt >= HOLD_LAST) begin
                    owner_nxt = OWN_DBG;
                    hold_nxt  = '0;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            OWN_DBG: begin
                if (!bus.dbg_req) begin
                    owner_nxt = cpu_ok ? OWN_CPU : OWN_NONE;
                    hold_nxt  = '0;
                end else if (cpu_ok && hold_cnt >= HOLD_LAST) begin
                    owner_nxt = OWN_CPU;
                    hold_nxt  = '0;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                owner_nxt = OWN_NONE;
                hold_nxt  = '0;
            end
        endcase
    end

    // RAM port follows the registered owner; everything is zero when no access is made.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (owner == OWN_CPU && bus.cpu_req) begin
            ram_en    = 1'b1;
            ram_we    = bus.cpu_we;
            ram_addr  = bus.cpu_addr;
            ram_wdata = bus.cpu_wdata;
        end else if (owner == OWN_DBG && bus.dbg_req) begin
            ram_en    = 1'b1;
            ram_we    = bus.dbg_we;
            ram_addr  = bus.dbg_addr;
            ram_wdata = bus.dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner      <= OWN_NONE;
            last_cpu   <= 1'b0;
            hold_cnt   <= '0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            rdata      <= '0;
        end else begin
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            if (owner_nxt != owner && owner_nxt != OWN_NONE)
                last_cpu <= (owner_nxt == OWN_CPU);
            // Tag comes from the owner that made the read, so it survives a handover.
            cpu_rvalid <= ram_en & ~ram_we & (owner == OWN_CPU);
            dbg_rvalid <= ram_en & ~ram_we & (owner == OWN_DBG);
            rdata      <= bus.ram_rdata;
        end
    end

    assign bus.cpu_gnt    = (owner == OWN_CPU);
    assign bus.dbg_gnt    = (owner == OWN_DBG);
    assign bus.cpu_stall  = bus.cpu_req & (owner != OWN_CPU);
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.rdata      = rdata;
    assign bus.ram_en     = ram_en;
    assign bus.ram_we     = ram_we;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_wdata  = ram_wdata;
endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Bench for mcpu_mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a rule-level ownership model and a shadow copy of the RAM.
module tb_mcpu_mem_arbiter;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wd;
    } port_t;

    logic clk;
    logic reset;
    logic reset_seen;
    int   checks;
    int   errors;

    mcpu_mem_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    mcpu_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(int i);
        if (i == 0)
            return 16'h1E1A;
        else if (i == 'h64)
            return 16'h001A;
        else
            return 16'(i * 3 + 7);
    endfunction

    // RAM with asynchronous read so the registered rdata lines up with rvalid.
    logic [15:0] mem [256];
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge clk) begin
        if (!reset_seen) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= init_val(i);
        end else if (bus.ram_en && bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    // Ownership: 0 none, 1 cpu, 2 dbg. m_run counts accesses in the current tenure.
    int          m_owner;
    int          m_last;
    int          m_run;
    int          m_pend;
    logic [15:0] m_rdata;
    logic        m_valid;
    logic [15:0] shadow [256];

    function automatic port_t exp_port(int own);
        port_t p;
        p = '0;
        if (own == 1 && bus.cpu_req) begin
            p.en = 1'b1; p.we = bus.cpu_we; p.addr = bus.cpu_addr; p.wd = bus.cpu_wdata;
        end else if (own == 2 && bus.dbg_req) begin
            p.en = 1'b1; p.we = bus.dbg_we; p.addr = bus.dbg_addr; p.wd = bus.dbg_wdata;
        end
        return p;
    endfunction

    initial begin
        m_owner = 0; m_last = 2; m_run = 0; m_pend = 0; m_rdata = '0; m_valid = 1'b0;
    end

    always @(posedge clk) begin
        port_t       p;
        int          nxt, nrun, other, npend;
        logic        cpu_want, dbg_want, other_want;
        logic [15:0] nrd;
        nxt = 0; nrun = 0; npend = 0; nrd = '0;
        if (m_valid) begin
            p = exp_port(m_owner);
            nrd = shadow[p.addr];
            if (p.en && p.we) shadow[p.addr] = p.wd;
            npend = (p.en && !p.we) ? m_owner : 0;
            cpu_want = bus.cpu_req && !bus.dbg_lock;
            dbg_want = bus.dbg_req;
            if (m_owner == 0) begin
                if (cpu_want && dbg_want) nxt = (m_last == 1) ? 2 : 1;
                else nxt = cpu_want ? 1 : (dbg_want ? 2 : 0);
                nrun = 0;
            end else begin
                other = 3 - m_owner;
                other_want = (other == 1) ? cpu_want : dbg_want;
                if (!p.en || (m_owner == 1 && bus.dbg_lock)) begin
                    nxt = other_want ? other : 0;
                    nrun = 0;
                end else if (other_want && m_run + 1 >= MAX_HOLD) begin
                    nxt = other;
                    nrun = 0;
                end else begin
                    nxt = m_owner;
                    nrun = m_run + 1;
                end
            end
        end
        if (!reset) begin
            if (!m_valid)
                for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
            m_owner = 0; m_last = 2; m_run = 0; m_pend = 0; m_rdata = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (nxt != 0 && nxt != m_owner) m_last = nxt;
            m_owner = nxt; m_run = nrun; m_pend = npend; m_rdata = nrd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        port_t e;
        if (!m_valid) return;
        e = exp_port(m_owner);
        chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(m_owner == 1));
        chk("dbg_gnt",    32'(bus.dbg_gnt),    32'(m_owner == 2));
        chk("ram_en",     32'(bus.ram_en),     32'(e.en));
        chk("ram_we",     32'(bus.ram_we),     32'(e.en & e.we));
        chk("ram_addr",   32'(bus.ram_addr),   32'(e.addr));
        chk("ram_wdata",  32'(bus.ram_wdata),  32'(e.wd));
        chk("cpu_stall",  32'(bus.cpu_stall),  32'(bus.cpu_req && m_owner != 1));
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_pend == 1));
        chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(m_pend == 2));
        chk("rdata",      32'(bus.rdata),      32'(m_rdata));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [15:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [7:0] a, input logic [15:0] d);
        bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0; errors = 0; n = 0;
        reset = 1'b0; reset_seen = 1'b0; bus.dbg_lock = 1'b0;
        set_cpu(1'b1, 1'b0, 8'h00, 16'h0000);
        set_dbg(1'b1, 1'b0, 8'h20, 16'h0000);
        tick(); tick();
        chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
        chk("rst_dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        chk("rst_ram_en",     32'(bus.ram_en),     32'd0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rst_rdata",      32'(bus.rdata),      32'd0);

        reset_seen = 1'b1; reset = 1'b1;
        set_dbg(1'b0, 1'b0, 8'h20, 16'h0000);
        tick();
        chk("first_cpu_gnt",  32'(bus.cpu_gnt),  32'd1);
        chk("first_ram_addr", 32'(bus.ram_addr), 32'h00);
        tick();
        chk("first_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("first_rdata",      32'(bus.rdata),      32'h1E1A);
        bus.cpu_req = 1'b0;
        tick();
        chk("cpu_release", 32'(bus.cpu_gnt), 32'd0);

        // CPU was served last, so the tie goes to debug.
        set_cpu(1'b1, 1'b0, 8'h10, 16'h0000);
        set_dbg(1'b1, 1'b0, 8'h20, 16'h0000);
        tick();
        chk("tie_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        tick();
        chk("tie_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("tie_dbg_rdata",  32'(bus.rdata),      32'h0067);
        bus.dbg_req = 1'b0;
        tick();
        chk("handover_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        chk("handover_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);

        set_dbg(1'b1, 1'b1, 8'hC8, 16'h0063);
        for (int k = 0; k < 20; k++) begin
            if (bus.dbg_gnt) break;
            if (bus.cpu_gnt) begin
                bus.cpu_addr = 8'(n);
                n++;
            end
            tick();
        end
        chk("hold_dbg_gnt",   32'(bus.dbg_gnt), 32'd1);
        chk("hold_cpu_count", 32'(n),           32'd4);
        tick();
        bus.dbg_req = 1'b0;
        chk("hold_write_mem", 32'(mem[8'hC8]),  32'h0063);
        tick();
        chk("hold_cpu_resume", 32'(bus.cpu_gnt), 32'd1);

        bus.dbg_lock = 1'b1;
        tick();
        chk("lock_cpu_gnt",   32'(bus.cpu_gnt),   32'd0);
        chk("lock_cpu_stall", 32'(bus.cpu_stall), 32'd1);
        bus.dbg_lock = 1'b0;
        tick();
        chk("lock_regrant", 32'(bus.cpu_gnt), 32'd1);

        tick(); tick(); tick();
        bus.cpu_addr = 8'h64;
        set_dbg(1'b1, 1'b0, 8'h30, 16'h0000);
        tick();
        chk("tag_dbg_gnt",    32'(bus.dbg_gnt),    32'd1);
        chk("tag_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("tag_rdata",      32'(bus.rdata),      32'h001A);
        chk("tag_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);

        bus.cpu_req = 1'b0;
        reset = 1'b0;
        tick();
        chk("midrst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("midrst_dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        reset = 1'b1;
        bus.dbg_req = 1'b0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            set_cpu(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 3),
                    8'($urandom_range(0, 255)), 16'($urandom));
            set_dbg(1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 9) < 4),
                    8'($urandom_range(0, 255)), 16'($urandom));
            if ($urandom_range(0, 19) == 0) bus.dbg_lock = ~bus.dbg_lock;
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        reset = 1'b1; bus.dbg_lock = 1'b0;
        set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
        set_dbg(1'b0, 1'b0, 8'h00, 16'h0000);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
